// File: rtl/cache_access_sequencer.sv
// cache_access_sequencer: walks a linear word-address range, one cache access at a time, counting hits and misses.
module cache_access_sequencer #(
  parameter int ADDR_W       = 15,
  parameter int START_ADDR   = 1024,
  parameter int NUM_ACCESSES = 8192,
  parameter int CNT_W        = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              finish_IN,
  input  logic              hit_IN,
  output logic [ADDR_W-1:0] address,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic [CNT_W-1:0]  access_count
);
  typedef enum logic [1:0] {IDLE, WAIT, STEP, DONE} state_t;
  localparam logic [ADDR_W-1:0] START = ADDR_W'(START_ADDR);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(NUM_ACCESSES - 1);
  state_t state;
  logic   last;
  always_comb last = access_count == LAST;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state        <= IDLE;
      address      <= START;
      busy         <= 1'b0;
      done         <= 1'b0;
      hit_count    <= '0;
      miss_count   <= '0;
      access_count <= '0;
    end else
      case (state)
        IDLE, DONE:
          if (start) begin
            state        <= WAIT;
            address      <= START;
            busy         <= 1'b1;
            done         <= 1'b0;
            hit_count    <= '0;
            miss_count   <= '0;
            access_count <= '0;
          end
        WAIT:
          if (finish_IN) begin
            access_count <= access_count + CNT_W'(1);
            hit_count    <= hit_count + CNT_W'(hit_IN);
            miss_count   <= miss_count + CNT_W'(!hit_IN);
            state        <= last ? DONE : STEP;
            busy         <= !last;
            done         <= last;
          end
        // one-cycle bubble so the cache sees finish_IN drop before the next address
        STEP: begin
          address <= address + ADDR_W'(1);
          state   <= WAIT;
        end
      endcase
endmodule

// File: tb/tb_cache_access_sequencer.sv
// tb_cache_access_sequencer: random cache latency/hit stimulus against a per-access expected-value model.
module tb_cache_access_sequencer;
  localparam int AW = 15, CW = 14, SA = 32764, NA = 10;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, finish_in = 1'b0, hit_in = 1'b0;
  logic [AW-1:0] address;
  logic busy, done;
  logic [CW-1:0] hit_count, miss_count, access_count;
  int n_cmp = 0, n_bad = 0;
  bit pat [NA];
  int h_first;

  cache_access_sequencer #(.ADDR_W(AW), .START_ADDR(SA), .NUM_ACCESSES(NA), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .start(start), .finish_IN(finish_in), .hit_IN(hit_in),
    .address(address), .busy(busy), .done(done),
    .hit_count(hit_count), .miss_count(miss_count), .access_count(access_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_state(input string tag, input int a, input int h, input int m, input bit b, input bit d);
    chk({tag, ".address"}, 32'(address), a);
    chk({tag, ".hit_count"}, 32'(hit_count), h);
    chk({tag, ".miss_count"}, 32'(miss_count), m);
    chk({tag, ".access_count"}, 32'(access_count), h + m);
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".done"}, 32'(done), 32'(d));
  endtask

  // one run: start, NA accesses with random latency, optional async abort after abort_at finishes
  task automatic run(input int abort_at, input bit reuse, output int h_out);
    int h = 0, m = 0, a = 0;
    bit hp;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    expect_state("launch", SA, 0, 0, 1'b1, 1'b0);
    for (int k = 0; k < NA; k++) begin
      a = (SA + k) % (1 << AW);
      repeat ($urandom_range(0, 3)) begin
        start = 1'($urandom_range(0, 1));
        @(negedge clk) start = 1'b0;
        expect_state("wait", a, h, m, 1'b1, 1'b0);
      end
      hp = reuse ? pat[k] : 1'($urandom_range(0, 1));
      pat[k] = hp;
      finish_in = 1'b1;
      hit_in = hp;
      @(negedge clk) begin finish_in = 1'b0; hit_in = 1'b0; end
      if (hp) h++; else m++;
      if (k == NA - 1) begin
        expect_state("done", a, h, m, 1'b0, 1'b1);
        break;
      end
      expect_state("step", a, h, m, 1'b1, 1'b0);
      if (abort_at == k + 1) begin
        #2 rst = 1'b1;
        #1 expect_state("abort", SA, 0, 0, 1'b0, 1'b0);
        @(negedge clk) rst = 1'b0;
        h_out = 0;
        return;
      end
      finish_in = 1'($urandom_range(0, 1));
      hit_in = 1'b1;
      start = 1'($urandom_range(0, 1));
      @(negedge clk) begin finish_in = 1'b0; hit_in = 1'b0; start = 1'b0; end
    end
    repeat (2) begin
      finish_in = 1'b1;
      hit_in = 1'b1;
      @(negedge clk) begin finish_in = 1'b0; hit_in = 1'b0; end
      expect_state("done_hold", a, h, m, 1'b0, 1'b1);
    end
    h_out = h;
  endtask

  initial begin
    int h;
    repeat (2) @(negedge clk);
    expect_state("reset", SA, 0, 0, 1'b0, 1'b0);
    rst = 1'b0;
    finish_in = 1'b1;
    hit_in = 1'b1;
    @(negedge clk) begin finish_in = 1'b0; hit_in = 1'b0; end
    expect_state("idle_finish", SA, 0, 0, 1'b0, 1'b0);
    run(0, 1'b0, h_first);
    run(2, 1'b0, h);
    run(0, 1'b0, h_first);
    run(0, 1'b1, h);
    chk("restart_repeat_hits", 32'(h), 32'(h_first));
    repeat (5) run(0, 1'b0, h);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cache_access_sequencer.md
Name: cache_access_sequencer

Overview:
- Upstream request stage for the direct-mapped data cache circuit: walks a linear range of 15-bit word addresses and presents one address at a time.
- Holds each address stable until the cache pulses finish, samples hit in the same cycle, and counts hits and misses.
- Raises done after the last access so the hit rate (hit_count / NUM_ACCESSES) can be read.

Parameters:
- ADDR_W, 15, address width; matches the cache address port.
- START_ADDR, 1024, first word address issued.
- NUM_ACCESSES, 8192, number of accesses per run; must be ≥1 and < 2^CNT_W.
- CNT_W, 14, width of the hit, miss and access counters.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a run; honoured only in IDLE or DONE.
- finish_IN  input  1  cache finish_OUT; a one-cycle pulse marks completion of the current access.
- hit_IN  input  1  cache hit_OUT; sampled only in the cycle finish_IN=1.
- address  output  ADDR_W  address presented to the cache.
- busy  output  1  high in WAIT or STEP.
- done  output  1  high in DONE; held until start or rst.
- hit_count  output  CNT_W  hits in the current or last run.
- miss_count  output  CNT_W  misses in the current or last run.
- access_count  output  CNT_W  accesses completed in the current or last run.

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - address=START_ADDR; all counters=0; busy=0; done=0.
  - Reset mid-run aborts the run immediately; no partial result is kept.
- States: IDLE, WAIT, STEP, DONE.
- IDLE:
  - address=START_ADDR; finish_IN is ignored.
  - start=1 -> WAIT. Counters are cleared on this edge, and busy=1 from the next cycle.
- WAIT:
  - address is held constant.
  - finish_IN=0 -> stay in WAIT; no timeout.
  - finish_IN=1 -> access_count+1, and hit_count+1 if hit_IN=1, otherwise miss_count+1.
  - If the incremented access_count equals NUM_ACCESSES -> DONE; otherwise -> STEP.
- STEP (exactly one cycle):
  - address <= address+1, modulo 2^ADDR_W: 32767 wraps to 0.
  - Next state is WAIT.
  - The bubble guarantees the cache controller sees finish_IN deassert before the new address is consumed.
  - finish_IN in STEP is ignored and not counted.
- DONE:
  - done=1, busy=0; counters and address are frozen at their final values.
  - start=1 -> counters cleared, address=START_ADDR, state -> WAIT (restart).
  - finish_IN is ignored.
- start in WAIT or STEP is ignored, with no effect on counters or address.
- Invariant at every edge: hit_count+miss_count == access_count.
- Latency:
  - The first address is valid in the cycle after start (IDLE already drives START_ADDR).
  - Per access: cache latency plus one STEP cycle.
  - done asserts the cycle after the final finish_IN.
- All outputs are registered; no combinational path from inputs to outputs.

Test Plan:
- Basic run, NUM_ACCESSES=4, START_ADDR=1024, finish_IN pulsed 3 cycles after each address change with hit pattern 0,1,1,1:
  - addresses presented are 1024,1025,1026,1027.
  - hit_count=3, miss_count=1, access_count=4.
  - done=1 one cycle after the 4th finish; busy=0.
- Default parameters, cache model hitting on every access whose address[1:0]!=0:
  - after 8192 accesses, hit_count=6144, miss_count=2048, done=1.
  - last address observed is 9215.
- Wrap case, START_ADDR=32766, NUM_ACCESSES=4:
  - addresses presented are 32766,32767,0,1; access_count=4.
- Reset mid-run: assert rst asynchronously (between edges) after 2 finishes:
  - outputs immediately show address=START_ADDR, counters=0, busy=0, done=0.
  - a subsequent start gives a clean run.
- Ignored inputs:
  - start pulsed in WAIT and in STEP -> no counter clear, no address change.
  - finish_IN pulsed in IDLE, STEP and DONE -> counters unchanged.
- Restart from DONE: start pulsed while done=1:
  - counters reset to 0, address=START_ADDR, busy=1 next cycle.
  - second run reproduces the first run's counts.
